// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Package     : video_pkg
// Description : Shared encodings and colour constants for the video test-pattern
//               source. Pattern-mode codes, the eight colour-bar values and the
//               BLACK/WHITE/BLUE constants used by the pixel selector.
// Revision    : 1.0  initial release
// ============================================================================
package video_pkg;

  // Pattern selection codes, as driven on mode_in
  typedef enum logic [1:0] {
    PAT_BARS = 2'd0,
    PAT_GRID = 2'd1,
    PAT_GRAD = 2'd2,
    PAT_BOX  = 2'd3
  } pat_mode_e;

  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLUE  = 24'h0000FF;

  // Standard colour bars, left to right
  localparam logic [23:0] BAR_RGB [0:7] = '{
    24'hFFFFFF,  // white
    24'hFFFF00,  // yellow
    24'h00FFFF,  // cyan
    24'h00FF00,  // green
    24'hFF00FF,  // magenta
    24'hFF0000,  // red
    24'h0000FF,  // blue
    24'h000000   // black
  };

endpackage : video_pkg
`default_nettype wire

// File: rtl/pat_box_motion.sv
`default_nettype none
// ============================================================================
// Module      : pat_box_motion
// Description : Position state of the bouncing box. On each frame-start strobe
//               the box moves STEP pixels along each axis and reverses direction
//               when it reaches an edge of the active area (clamped to the edge).
// Ports       : clk, rstn (sync, active-low)
//               frame_start_i  one-cycle strobe at the start of each frame
//               box_x_o/box_y_o top-left corner of the box, active coordinates
// Revision    : 1.0  initial release
// ============================================================================
module pat_box_motion #(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12,
  parameter int H_ACT  = 1920,
  parameter int V_ACT  = 1080,
  parameter int BOX    = 64,
  parameter int STEP   = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              frame_start_i,
  output logic [X_BITS-1:0] box_x_o,
  output logic [Y_BITS-1:0] box_y_o
);

  // Right/bottom-most legal position and the threshold at which the next step
  // would overshoot it.
  localparam logic [X_BITS-1:0] X_MAX  = X_BITS'(H_ACT - BOX);
  localparam logic [X_BITS-1:0] X_TURN = X_BITS'(H_ACT - BOX - STEP);
  localparam logic [X_BITS-1:0] X_STEP = X_BITS'(STEP);
  localparam logic [Y_BITS-1:0] Y_MAX  = Y_BITS'(V_ACT - BOX);
  localparam logic [Y_BITS-1:0] Y_TURN = Y_BITS'(V_ACT - BOX - STEP);
  localparam logic [Y_BITS-1:0] Y_STEP = Y_BITS'(STEP);

  logic [X_BITS-1:0] box_x_q, box_x_d;
  logic [Y_BITS-1:0] box_y_q, box_y_d;
  logic              right_q, right_d;   // 1: moving right
  logic              down_q,  down_d;    // 1: moving down

  always_comb begin
    box_x_d = box_x_q;
    right_d = right_q;
    if (right_q) begin
      if (box_x_q >= X_TURN) begin
        box_x_d = X_MAX;
        right_d = 1'b0;
      end else begin
        box_x_d = box_x_q + X_STEP;
      end
    end else begin
      if (box_x_q <= X_STEP) begin
        box_x_d = '0;
        right_d = 1'b1;
      end else begin
        box_x_d = box_x_q - X_STEP;
      end
    end
  end

  always_comb begin
    box_y_d = box_y_q;
    down_d  = down_q;
    if (down_q) begin
      if (box_y_q >= Y_TURN) begin
        box_y_d = Y_MAX;
        down_d  = 1'b0;
      end else begin
        box_y_d = box_y_q + Y_STEP;
      end
    end else begin
      if (box_y_q <= Y_STEP) begin
        box_y_d = '0;
        down_d  = 1'b1;
      end else begin
        box_y_d = box_y_q - Y_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      box_x_q <= '0;
      box_y_q <= '0;
      right_q <= 1'b1;
      down_q  <= 1'b1;
    end else if (frame_start_i) begin
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      right_q <= right_d;
      down_q  <= down_d;
    end
  end

  assign box_x_o = box_x_q;
  assign box_y_o = box_y_q;

endmodule : pat_box_motion
`default_nettype wire

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_pattern_gen
// Description : Test-pattern source placed after the HDMI timing generator.
//               Produces colour bars, grid, gradient or a bouncing box from the
//               incoming active coordinates, with sync/DE delayed to match the
//               two-stage pixel pipeline. Mode is latched at frame start.
// Ports       : clk, rstn (sync, active-low)
//               mode_in              requested pattern (see video_pkg)
//               vs_in/hs_in/de_in    timing from the timing generator
//               x_in/y_in            active coordinates, valid with de_in
//               vs_out/hs_out/de_out timing delayed by 2 clk
//               r_out/g_out/b_out    pixel colour, 0 when de_out is low
//               frame_cnt            frames started since reset (wraps)
// Revision    : 1.0  initial release
// ============================================================================
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12,
  parameter int H_ACT  = 1920,
  parameter int V_ACT  = 1080,
  parameter int BOX    = 64,
  parameter int STEP   = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        mode_in,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  input  logic [X_BITS-1:0] x_in,
  input  logic [Y_BITS-1:0] y_in,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [7:0]        r_out,
  output logic [7:0]        g_out,
  output logic [7:0]        b_out,
  output logic [7:0]        frame_cnt
);

  localparam int BAR_W = H_ACT / 8;

  // ---------------------------------------------------------------- frame start
  logic      vs_prev_q;
  logic      frame_start;
  pat_mode_e mode_q;
  logic [7:0] frame_cnt_q;

  // Stage-0 edge: the update lands on the same edge that sees vs rise, well
  // ahead of the first active pixel of the frame.
  assign frame_start = vs_in & ~vs_prev_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vs_prev_q   <= 1'b0;
      mode_q      <= PAT_BARS;
      frame_cnt_q <= '0;
    end else begin
      vs_prev_q <= vs_in;
      if (frame_start) begin
        mode_q      <= pat_mode_e'(mode_in);
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  logic [X_BITS-1:0] box_x;
  logic [Y_BITS-1:0] box_y;

  pat_box_motion #(
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS),
    .H_ACT  (H_ACT),
    .V_ACT  (V_ACT),
    .BOX    (BOX),
    .STEP   (STEP)
  ) u_box_motion (
    .clk           (clk),
    .rstn          (rstn),
    .frame_start_i (frame_start),
    .box_x_o       (box_x),
    .box_y_o       (box_y)
  );

  // ---------------------------------------------------- stage 1: predicates
  logic [2:0]      bar_idx_d;
  logic            grid_d;
  logic            box_d;
  logic [X_BITS:0] grad_sum_d;
  logic [7:0]      grad_b_d;

  // Bar index by threshold comparison; the last threshold passed wins.
  always_comb begin
    bar_idx_d = '0;
    for (int k = 1; k < 8; k++) begin
      if (x_in >= X_BITS'(k * BAR_W)) begin
        bar_idx_d = 3'(k);
      end
    end
  end

  assign grid_d = (x_in[5:0] == 6'd0) || (y_in[5:0] == 6'd0) ||
                  (x_in == X_BITS'(H_ACT - 1)) || (y_in == Y_BITS'(V_ACT - 1));

  // Upper bounds are compared one bit wider so box_x + BOX cannot wrap.
  assign box_d = (x_in >= box_x) &&
                 ({1'b0, x_in} < ({1'b0, box_x} + (X_BITS+1)'(BOX))) &&
                 (y_in >= box_y) &&
                 ({1'b0, y_in} < ({1'b0, box_y} + (Y_BITS+1)'(BOX)));

  assign grad_sum_d = {1'b0, x_in} + (X_BITS+1)'(y_in);
  assign grad_b_d   = 8'(grad_sum_d >> 1);

  logic       vs1_q, hs1_q, de1_q;
  logic [2:0] bar_idx_q;
  logic       grid_q, box_q;
  logic [7:0] grad_r_q, grad_g_q, grad_b_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vs1_q     <= 1'b0;
      hs1_q     <= 1'b0;
      de1_q     <= 1'b0;
      bar_idx_q <= '0;
      grid_q    <= 1'b0;
      box_q     <= 1'b0;
      grad_r_q  <= '0;
      grad_g_q  <= '0;
      grad_b_q  <= '0;
    end else begin
      vs1_q     <= vs_in;
      hs1_q     <= hs_in;
      de1_q     <= de_in;
      bar_idx_q <= bar_idx_d;
      grid_q    <= grid_d;
      box_q     <= box_d;
      grad_r_q  <= x_in[7:0];
      grad_g_q  <= y_in[7:0];
      grad_b_q  <= grad_b_d;
    end
  end

  // ------------------------------------------------ stage 2: select + blank
  logic [23:0] rgb_d;

  always_comb begin
    rgb_d = BLACK;
    if (de1_q) begin
      unique case (mode_q)
        PAT_BARS: rgb_d = BAR_RGB[bar_idx_q];
        PAT_GRID: rgb_d = grid_q ? WHITE : BLACK;
        PAT_GRAD: rgb_d = {grad_r_q, grad_g_q, grad_b_q};
        PAT_BOX:  rgb_d = box_q ? WHITE : BLUE;
        default:  rgb_d = BLACK;
      endcase
    end
  end

  logic        vs2_q, hs2_q, de2_q;
  logic [23:0] rgb_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vs2_q <= 1'b0;
      hs2_q <= 1'b0;
      de2_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      vs2_q <= vs1_q;
      hs2_q <= hs1_q;
      de2_q <= de1_q;
      rgb_q <= rgb_d;
    end
  end

  assign vs_out    = vs2_q;
  assign hs_out    = hs2_q;
  assign de_out    = de2_q;
  assign r_out     = rgb_q[23:16];
  assign g_out     = rgb_q[15:8];
  assign b_out     = rgb_q[7:0];
  assign frame_cnt = frame_cnt_q;

endmodule : video_pattern_gen
`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_pattern_gen
// Description : Self-checking bench for video_pattern_gen on a 64x32 geometry.
//               A reference model computes each output directly from the pattern
//               rules; directed pixels with literal colours pin the model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_video_pattern_gen;

  localparam int H_ACT = 64;
  localparam int V_ACT = 32;
  localparam int BOX   = 8;
  localparam int STEP  = 2;
  localparam int H_TOT = 80;
  localparam int V_TOT = 36;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  mode_in = 2'd0;
  logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
  logic [11:0] x_in = '0, y_in = '0;
  logic        vs_out, hs_out, de_out;
  logic [7:0]  r_out, g_out, b_out, frame_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_pattern_gen #(
    .X_BITS (12), .Y_BITS (12), .H_ACT (H_ACT), .V_ACT (V_ACT),
    .BOX (BOX), .STEP (STEP)
  ) dut (
    .clk (clk), .rstn (rstn), .mode_in (mode_in),
    .vs_in (vs_in), .hs_in (hs_in), .de_in (de_in),
    .x_in (x_in), .y_in (y_in),
    .vs_out (vs_out), .hs_out (hs_out), .de_out (de_out),
    .r_out (r_out), .g_out (g_out), .b_out (b_out),
    .frame_cnt (frame_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  logic [23:0] bars [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Box travel is a triangle wave over [0, span]; valid because STEP divides
  // both spans exactly in this geometry.
  function automatic int tri_pos(input int n, input int span);
    int p;
    p = (STEP * n) % (2 * span);
    return (p <= span) ? p : 2 * span - p;
  endfunction

  function automatic logic [23:0] model_rgb(input logic de, input int x, input int y,
                                            input int mode, input int n);
    int bx, by;
    if (!de) return 24'h0;
    case (mode)
      0: return bars[x / (H_ACT / 8)];
      1: return ((x % 64 == 0) || (y % 64 == 0) || x == H_ACT - 1 || y == V_ACT - 1)
                ? 24'hFFFFFF : 24'h000000;
      2: return {8'(x % 256), 8'(y % 256), 8'(((x + y) / 2) % 256)};
      default: begin
        bx = tri_pos(n, H_ACT - BOX);
        by = tri_pos(n, V_ACT - BOX);
        return (x >= bx && x < bx + BOX && y >= by && y < by + BOX)
               ? 24'hFFFFFF : 24'h0000FF;
      end
    endcase
  endfunction

  int          m_n = 0;
  int          m_mode = 0;
  logic        m_prev_vs = 1'b0;
  logic [26:0] pend = '0;
  logic [26:0] exp_out = '0;
  int          exp_fc = 0;
  logic        m_started = 1'b0;

  always @(posedge clk) begin
    exp_out = pend;
    if (!rstn) begin
      m_n = 0; m_mode = 0; m_prev_vs = 1'b0; pend = '0; exp_out = '0;
    end else begin
      if (vs_in && !m_prev_vs) begin
        m_n++;
        m_mode = int'(mode_in);
      end
      m_prev_vs = vs_in;
      pend = {vs_in, hs_in, de_in, model_rgb(de_in, int'(x_in), int'(y_in), m_mode, m_n)};
    end
    exp_fc = m_n % 256;
    m_started = 1'b1;
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("pipe", {5'b0, vs_out, hs_out, de_out, r_out, g_out, b_out}, {5'b0, exp_out});
      chk("frame_cnt", {24'b0, frame_cnt}, 32'(exp_fc));
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(); rstn = 1'b0; vs_in = 0; hs_in = 0; de_in = 0;
    step(); step(); rstn = 1'b1;
  endtask

  task automatic vs_pulse();
    step(); vs_in = 1'b1; de_in = 1'b0;
    step(); step(); vs_in = 1'b0;
    step(); step();
  endtask

  task automatic px_check(input string name, input int x, input int y,
                          input logic de, input logic [23:0] exp_rgb);
    step(); de_in = de; x_in = 12'(x); y_in = 12'(y); vs_in = 0; hs_in = 0;
    step(); de_in = 1'b0; x_in = '0; y_in = '0;
    @(posedge clk);
    @(negedge clk);
    chk({name, "_rgb"}, {8'h0, r_out, g_out, b_out}, {8'h0, exp_rgb});
    chk({name, "_de"}, {31'b0, de_out}, {31'b0, de});
  endtask

  task automatic full_frame();
    for (int ln = 0; ln < V_TOT; ln++) begin
      if ($urandom_range(0, 7) == 0) mode_in = 2'($urandom_range(0, 3));
      for (int c = 0; c < H_TOT; c++) begin
        step();
        de_in = (ln < V_ACT) && (c < H_ACT);
        x_in  = de_in ? 12'(c) : 12'h0;
        y_in  = de_in ? 12'(ln) : 12'h0;
        hs_in = (c >= 68) && (c < 74);
        vs_in = (ln >= 33) && (ln < 35);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("reset_out", {5'b0, vs_out, hs_out, de_out, r_out, g_out, b_out}, 32'h0);
    chk("reset_fc", {24'b0, frame_cnt}, 32'h0);

    // Bars
    mode_in = 2'd0;
    vs_pulse();
    px_check("bar_x0", 0, 0, 1'b1, 24'hFFFFFF);
    px_check("bar_x8", 8, 0, 1'b1, 24'hFFFF00);
    px_check("bar_x63", 63, 0, 1'b1, 24'h000000);

    // Mode change mid-frame waits for the next frame start
    mode_in = 2'd2;
    px_check("latch_old", 5, 3, 1'b1, 24'hFFFFFF);
    vs_pulse();
    px_check("latch_grad", 5, 3, 1'b1, 24'h050304);

    // Grid and blanking
    mode_in = 2'd1;
    vs_pulse();
    px_check("grid_0_10", 0, 10, 1'b1, 24'hFFFFFF);
    px_check("grid_1_1", 1, 1, 1'b1, 24'h000000);
    px_check("grid_63_5", 63, 5, 1'b1, 24'hFFFFFF);
    px_check("grid_blank", 0, 10, 1'b0, 24'h000000);

    // Box bounce
    do_reset();
    mode_in = 2'd3;
    repeat (28) vs_pulse();
    @(negedge clk);
    chk("box_fc28", {24'b0, frame_cnt}, 32'd28);
    px_check("box28_in", 56, 8, 1'b1, 24'hFFFFFF);
    px_check("box28_left", 55, 8, 1'b1, 24'h0000FF);
    px_check("box28_corner", 63, 15, 1'b1, 24'hFFFFFF);
    px_check("box28_below", 56, 16, 1'b1, 24'h0000FF);
    repeat (2) vs_pulse();
    @(negedge clk);
    chk("box_fc30", {24'b0, frame_cnt}, 32'd30);
    px_check("box30_in", 52, 12, 1'b1, 24'hFFFFFF);
    px_check("box30_right", 60, 12, 1'b1, 24'h0000FF);
    px_check("box30_left", 51, 12, 1'b1, 24'h0000FF);

    // Full frames from a timing-generator model with random mode requests
    repeat (3) full_frame();

    // Short randomized frames: random pixels at many box positions
    for (int f = 0; f < 200; f++) begin
      mode_in = 2'($urandom_range(0, 3));
      vs_pulse();
      for (int p = 0; p < 8; p++) begin
        step();
        de_in = ($urandom_range(0, 3) != 0);
        x_in  = 12'($urandom_range(0, H_ACT - 1));
        y_in  = 12'($urandom_range(0, V_ACT - 1));
        hs_in = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 3) == 0) mode_in = 2'($urandom_range(0, 3));
      end
      step(); de_in = 1'b0; hs_in = 1'b0;
    end

    // Frame counter wrap
    do_reset();
    repeat (255) vs_pulse();
    @(negedge clk);
    chk("fc_255", {24'b0, frame_cnt}, 32'd255);
    vs_pulse();
    @(negedge clk);
    chk("fc_wrap", {24'b0, frame_cnt}, 32'd0);

    // Reset for one cycle in the middle of a line
    mode_in = 2'd3;
    for (int c = 0; c < 20; c++) begin
      step();
      de_in = 1'b1; x_in = 12'(c); y_in = 12'd4; hs_in = 1'b0; vs_in = 1'b0;
      rstn = (c != 10);
      if (c == 11) begin
        @(negedge clk);
        chk("midrst_out", {5'b0, vs_out, hs_out, de_out, r_out, g_out, b_out}, 32'h0);
        chk("midrst_fc", {24'b0, frame_cnt}, 32'h0);
      end
    end
    step(); de_in = 1'b0;
    px_check("midrst_bars", 8, 0, 1'b1, 24'hFFFF00);

    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_video_pattern_gen
`default_nettype wire
